// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// default parameter values for byte width and the BUSY watchdog limit.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_BUSY  = 2'b10
    } state_t;

    localparam int DBIT_DEF    = 8;
    localparam int TIMEOUT_DEF = 200000;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker
// Combinational rotating-priority encoder. Returns the first set bit of req
// searching upward from rr_ptr and wrapping at NREQ.
//   req    in   NREQ  request vector
//   rr_ptr in   IW    index with highest priority
//   valid  out  1     any request set
//   idx    out  IW    winning index (0 when valid is low)
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)   // derived; leave at default
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        // Walk from lowest to highest priority so the nearest hit to rr_ptr
        // is the last one written and therefore wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[IW'((int'(rr_ptr) + k) % NREQ)]) begin
                valid = 1'b1;
                idx   = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Grants one requester, pulses tx_start with its byte, then waits in BUSY for
// tx_done_tick. A watchdog returns to IDLE and sets a sticky error if the
// transmitter never completes.
//   clk, reset    clock, asynchronous active-high reset
//   req           per-requester request level
//   din_bus       requester i byte at [i*DBIT +: DBIT]
//   ack / done    one-cycle per-requester accept / completion pulses
//   tx_start      start pulse to transmitter, tx_din its byte
//   tx_done_tick  completion pulse from transmitter
//   busy          high in START and BUSY (decoded from state)
//   grant_id      current/last granted requester
//   timeout_err   sticky watchdog flag, err_clr clears it
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DBIT    = DBIT_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int IW      = $clog2(NREQ)   // derived; leave at default
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DBIT-1:0] din_bus,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic                 tx_start,
    output logic [DBIT-1:0]      tx_din,
    input  logic                 tx_done_tick,
    output logic                 busy,
    output logic [IW-1:0]        grant_id,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int WW = $clog2(TIMEOUT);

    state_t                     r_state;
    logic [IW-1:0]              r_rr_ptr;
    logic [IW-1:0]              r_grant;
    logic [DBIT-1:0]            r_tx_din;
    logic                       r_tx_start;
    logic [NREQ-1:0]            r_ack;
    logic [NREQ-1:0]            r_done;
    logic                       r_timeout_err;
    logic [WW-1:0]              r_wdog;

    logic                       w_valid;
    logic [IW-1:0]              w_idx;
    logic [IW-1:0]              w_next_ptr;
    logic [NREQ-1:0][DBIT-1:0]  w_din;

    assign w_din      = din_bus;
    // Explicit wrap so non-power-of-two NREQ rotates correctly.
    assign w_next_ptr = (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_valid),
        .idx    (w_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_tx_din      <= '0;
            r_tx_start    <= 1'b0;
            r_ack         <= '0;
            r_done        <= '0;
            r_timeout_err <= 1'b0;
            r_wdog        <= '0;
        end else begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_done     <= '0;
            // A timeout below overrides this clear in the same cycle.
            if (err_clr) r_timeout_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant      <= w_idx;
                        r_tx_din     <= w_din[w_idx];
                        r_tx_start   <= 1'b1;
                        r_ack[w_idx] <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    r_wdog  <= '0;
                    r_state <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (tx_done_tick) begin
                        r_done[r_grant] <= 1'b1;
                        r_rr_ptr        <= w_next_ptr;
                        r_state         <= ST_IDLE;
                    end else if (r_wdog == WW'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_rr_ptr      <= w_next_ptr;
                        r_state       <= ST_IDLE;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign ack         = r_ack;
    assign done        = r_done;
    assign tx_start    = r_tx_start;
    assign tx_din      = r_tx_din;
    assign grant_id    = r_grant;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din_bus;
    logic [3:0]  ack, done;
    logic        tx_start;
    logic [7:0]  tx_din;
    logic        tx_done_tick;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic        err_clr;

    int npass = 0;
    int ntot  = 0;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];

    uart_tx_arbiter #(.NREQ(4), .DBIT(8), .TIMEOUT(50)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .din_bus      (din_bus),
        .ack          (ack),
        .done         (done),
        .tx_start     (tx_start),
        .tx_din       (tx_din),
        .tx_done_tick (tx_done_tick),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int id, input logic [7:0] data);
        exp_t e;
        e.id   = 2'(id);
        e.data = data;
        sb.push_back(e);
    endtask

    // Waits for tx_start, drops the requests in clr, pops and checks the grant.
    task automatic wait_start(input logic [3:0] clr, output int waited, output int gid);
        exp_t e;
        bit   seen;
        seen   = 0;
        waited = 0;
        gid    = 0;
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if (tx_start) seen = 1;
        end
        if (!seen) begin
            chk("start_seen", 0, 1);
            return;
        end
        req = req & ~clr;
        if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            return;
        end
        e   = sb.pop_front();
        gid = int'(e.id);
        chk("grant_id", grant_id, e.id);
        chk("tx_din", tx_din, e.data);
        chk("ack", ack, 32'd1 << e.id);
        chk("busy_start", busy, 1);
    endtask

    task automatic finish_tx(input int gid, input int dly);
        repeat (dly) @(negedge clk);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("done", done, 32'd1 << gid);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic serve(input logic [3:0] clr, input int dly);
        int w, g;
        wait_start(clr, w, g);
        finish_tx(g, dly);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int  w, g, cnt;
        bit  sawdone;

        reset = 1'b1; req = '0; din_bus = '0; tx_done_tick = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_tx_din", tx_din, 0);
        chk("rst_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Single request, one-cycle grant latency, tick 20 cycles after start
        din_bus = {8'h00, 8'hA5, 8'h00, 8'h00};
        req = 4'b0100; push(2, 8'hA5);
        wait_start(4'b0100, w, g);
        chk("latency", w, 1);
        finish_tx(g, 20);
        chk("grant_hold", grant_id, 2);
        chk("din_hold", tx_din, 8'hA5);

        // Wrap: rr_ptr=3, req 0101 -> 0 then 2
        din_bus = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b0101; push(0, 8'h11); push(2, 8'h33);
        serve(4'b0001, 3);
        serve(4'b0100, 3);

        // Stray ticks in IDLE and START
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("stray_idle_done", done, 0);
        chk("stray_idle_busy", busy, 0);
        chk("stray_idle_start", tx_start, 0);
        req = 4'b1000; push(3, 8'h44);
        wait_start(4'b1000, w, g);
        tx_done_tick = 1'b1;
        @(negedge clk);
        tx_done_tick = 1'b0;
        chk("stray_start_done", done, 0);
        chk("stray_start_busy", busy, 1);
        finish_tx(g, 2);

        // Fairness: all held, rr_ptr=0
        req = 4'b1111;
        push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
        push(0, 8'h11); push(1, 8'h22);
        for (int i = 0; i < 5; i++) serve(4'b0000, 3);
        serve(4'b1111, 3);

        // Timeout: rr_ptr=2, req 0001 -> grant 0, no tick
        din_bus = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req = 4'b0001; push(0, 8'hA1);
        wait_start(4'b0001, w, g);
        cnt = 0; sawdone = 0;
        while (!timeout_err && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (done != 0) sawdone = 1;
        end
        chk("timeout_cycles", cnt, 51);
        chk("timeout_no_done", sawdone, 0);
        chk("timeout_idle", busy, 0);
        req = 4'b0010; push(1, 8'hB2);
        serve(4'b0010, 3);
        chk("err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", timeout_err, 0);
        req = 4'b0100; push(2, 8'hC3);
        wait_start(4'b0100, w, g);
        repeat (50) @(negedge clk);
        chk("err_before_set", timeout_err, 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("set_wins", timeout_err, 1);
        chk("set_wins_idle", busy, 0);

        // Reset 5 cycles into BUSY: rr_ptr=3, req 0001 -> grant 0
        req = 4'b0001; push(0, 8'hA1);
        wait_start(4'b0001, w, g);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant_id, 0);
        chk("mid_rst_tx_din", tx_din, 0);
        chk("mid_rst_err", timeout_err, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_tx_start", tx_start, 0);
        @(negedge clk);
        reset = 1'b0;
        sawdone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done != 0) sawdone = 1;
        end
        chk("mid_rst_no_done", sawdone, 0);
        // From rr_ptr=0, req 1010 must pick 1 (rr_ptr=3 would pick 3)
        req = 4'b1010; push(1, 8'hB2);
        serve(4'b1010, 4);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
